hcode_ap_fifo128: RTL and testbench
===================================

Name: hcode_ap_fifo128

Overview:
- Single-clock 128-bit ap_fifo buffer placed between shell data movers and a subshell IP.
- Write side is the responder for an IP `out_r_*` port: accepts din/write and reports full.
- Read side is the responder for an IP `in_r_*` port: presents dout/empty_n and accepts read.
- First-word-fall-through semantics, so the head word is valid whenever empty_n=1.

Parameters:
- DATA_W, 128, word width.
- DEPTH, 16, number of entries; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH).
- AFULL_LVL, 12, occupancy at or above which wr_afull asserts; range 1..DEPTH.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ip_rst_n  in  1  reset; asynchronous assert, active-low; deassertion synchronised externally.
- wr_din  in  DATA_W  write data.
- wr_write  in  1  write strobe.
- wr_full  out  1  FIFO full, active-high; drives IP full_n through an inverter in the subshell.
- wr_afull  out  1  occupancy ≥ AFULL_LVL.
- rd_dout  out  DATA_W  head word; valid only when rd_empty_n=1.
- rd_empty_n  out  1  FIFO holds ≥1 word.
- rd_read  in  1  pop strobe.
- fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (ip_rst_n=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: wr_full=0, wr_afull=0, rd_empty_n=0, fifo_count=0, rd_dout=0.
  - Storage contents are not reset.
- Push: push = wr_write & ~wr_full.
  - Stores wr_din at mem[wr_ptr]; wr_ptr increments modulo DEPTH.
  - A write while wr_full=1 is dropped and leaves no state change.
- Pop: pop = rd_read & rd_empty_n.
  - rd_ptr increments modulo DEPTH.
  - A read while rd_empty_n=0 is ignored.
- Count update: count += push − pop; push and pop in the same cycle leave count unchanged.
- Status flags are registered and derived from next-cycle count:
  - wr_full = (count==DEPTH).
  - rd_empty_n = (count!=0).
  - wr_afull = (count≥AFULL_LVL).
- Latency: a word written at edge N is visible on rd_dout with rd_empty_n=1 after edge N (one-cycle write-to-read latency).
- rd_dout = mem[rd_ptr]. It is driven only from flops (no combinational path from wr_din). It is stable while rd_empty_n=1 and rd_read=0.
- Empty + write + read in the same cycle: the read is ignored and the word is stored; count becomes 1.
- Full + read + write in the same cycle: the pop succeeds and the write is dropped, since wr_full=1 at that edge; count becomes DEPTH−1.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no bubble. Ordering is strictly FIFO.
- Reset mid-stream: all buffered words are discarded immediately. rd_empty_n falls asynchronously with reset.

Optional Feature:
- Macro: HCODE_FIFO_ERR_EN.
- Defined: adds outputs err_ovf and err_udf (1 bit each). These are sticky flags.
  - err_ovf sets on wr_write & wr_full.
  - err_udf sets on rd_read & ~rd_empty_n.
  - Both clear only on reset; reset value 0.
- Undefined: the ports and logic are absent; dropped accesses are silent.

Decomposition:
- Package hcode_fifo_pkg holds:
  - the DATA_W default (128);
  - a function clog2_f for ADDR_W;
  - an enum-free localparam set for the default DEPTH/AFULL_LVL.
- One sub-module is natural: hcode_fifo_mem, a DEPTH×DATA_W flop array.
  - Inputs: write-enable/address/data.
  - Output: asynchronous read by address.
  - The top module keeps pointers, count and flags.

Test Plan:
- Reset then idle → rd_empty_n=0, wr_full=0, fifo_count=0. Assert rd_read 3 cycles → no state change; err_udf=1 if ERR_EN.
- Write 0x…01..0x…10 (16 words) on consecutive cycles → wr_afull rises after the 12th write, wr_full=1 after the 16th. A 17th write (0xDEAD) is dropped.
- Drain 16 words with rd_read held high → rd_dout sequence 0x…01..0x…10 in order, then rd_empty_n=0 and fifo_count=0.
- Continuous simultaneous read/write at count=5 for 40 cycles → fifo_count stays 5; data order is preserved across pointer wrap.
- Empty FIFO with wr_write=1 and rd_read=1 in the same cycle → next cycle: count=1 and rd_dout equals the written word. Full FIFO with both strobes → count=15 and the write is lost.
- Assert ip_rst_n=0 mid-cycle with count=9 → flags and fifo_count go to 0 without waiting for a clock edge. After release, the first write is read back correctly.

Source files
------------

// File: rtl/hcode_fifo_pkg.sv
// Shared defaults and helpers for the hcode ap_fifo buffers.
package hcode_fifo_pkg;

  localparam int DATA_W_DEF    = 128;
  localparam int DEPTH_DEF     = 16;
  localparam int AFULL_LVL_DEF = 12;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hcode_fifo_mem.sv
// DEPTH x DATA_W flop array: synchronous write, asynchronous read by address.
module hcode_fifo_mem #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hcode_ap_fifo128.sv
// First-word-fall-through ap_fifo between shell movers and a subshell IP; one-cycle write-to-read.
// Writes while full / reads while empty are dropped; HCODE_FIFO_ERR_EN adds sticky err_ovf/err_udf.
module hcode_ap_fifo128
  import hcode_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = clog2_f(DEPTH),
  parameter int AFULL_LVL = AFULL_LVL_DEF
) (
  input  logic              ap_clk,
  input  logic              ip_rst_n,
  input  logic [DATA_W-1:0] wr_din,
  input  logic              wr_write,
  output logic              wr_full,
  output logic              wr_afull,
  output logic [DATA_W-1:0] rd_dout,
  output logic              rd_empty_n,
  input  logic              rd_read,
  output logic [ADDR_W:0]   fifo_count
`ifdef HCODE_FIFO_ERR_EN
  ,output logic             err_ovf,
  output logic              err_udf
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_LVL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic [DATA_W-1:0] mem_rdata;
  logic              push;
  logic              pop;

  // Gating uses the registered flags, so a full+read+write cycle drops the write.
  assign push = wr_write & ~wr_full;
  assign pop  = rd_read & rd_empty_n;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_full    <= 1'b0;
      wr_afull   <= 1'b0;
      rd_empty_n <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      wr_full    <= (count_nxt == DEPTH_C);
      wr_afull   <= (count_nxt >= AFULL_C);
      rd_empty_n <= (count_nxt != '0);
    end
  end

`ifdef HCODE_FIFO_ERR_EN
  always_ff @(posedge ap_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | (wr_write & wr_full);
      err_udf <= err_udf | (rd_read & ~rd_empty_n);
    end
  end
`endif

  hcode_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (ap_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_din),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Masking with the registered flag keeps rd_dout at zero through reset and when empty.
  assign rd_dout    = rd_empty_n ? mem_rdata : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_hcode_ap_fifo128.sv
// Directed bench for hcode_ap_fifo128; err flag checks compile in with HCODE_FIFO_ERR_EN.
module tb_hcode_ap_fifo128;

  logic         ap_clk = 1'b0;
  logic         ip_rst_n;
  logic [127:0] wr_din;
  logic         wr_write;
  logic         wr_full;
  logic         wr_afull;
  logic [127:0] rd_dout;
  logic         rd_empty_n;
  logic         rd_read;
  logic [4:0]   fifo_count;
`ifdef HCODE_FIFO_ERR_EN
  logic         err_ovf;
  logic         err_udf;
`endif

  int n_chk = 0;
  int n_err = 0;

  hcode_ap_fifo128 dut (
    .ap_clk     (ap_clk),
    .ip_rst_n   (ip_rst_n),
    .wr_din     (wr_din),
    .wr_write   (wr_write),
    .wr_full    (wr_full),
    .wr_afull   (wr_afull),
    .rd_dout    (rd_dout),
    .rd_empty_n (rd_empty_n),
    .rd_read    (rd_read),
    .fifo_count (fifo_count)
`ifdef HCODE_FIFO_ERR_EN
    ,.err_ovf   (err_ovf),
    .err_udf    (err_udf)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Distinct byte in both top and bottom lanes catches lane/width slips.
  function automatic logic [127:0] word_f(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, 112'h0, b};
  endfunction

  initial begin
    ip_rst_n = 1'b0;
    wr_din   = '0;
    wr_write = 1'b0;
    rd_read  = 1'b0;
    #12;
    chk("rst_empty_n", rd_empty_n, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_afull", wr_afull, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_dout", rd_dout, 0);
    tick();
    ip_rst_n = 1'b1;

    // Reads on an empty FIFO change nothing.
    rd_read = 1'b1;
    repeat (3) tick();
    rd_read = 1'b0;
    chk("udf_count", fifo_count, 0);
    chk("udf_empty_n", rd_empty_n, 0);
`ifdef HCODE_FIFO_ERR_EN
    chk("udf_err", err_udf, 1);
    chk("udf_no_ovf", err_ovf, 0);
`endif

    // Fill to full.
    wr_write = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_din = word_f(i);
      tick();
      chk($sformatf("fill_count_%0d", i), fifo_count, 128'(i));
      chk($sformatf("fill_afull_%0d", i), wr_afull, (i >= 12) ? 1 : 0);
      chk($sformatf("fill_full_%0d", i), wr_full, (i == 16) ? 1 : 0);
    end
    wr_din = 128'hDEAD;
    tick();
    wr_write = 1'b0;
    chk("ovf_count", fifo_count, 16);
    chk("ovf_full", wr_full, 1);
`ifdef HCODE_FIFO_ERR_EN
    chk("ovf_err", err_ovf, 1);
`endif

    // Drain; 0xDEAD must not appear.
    rd_read = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain_dout_%0d", i), rd_dout, word_f(i));
      tick();
    end
    rd_read = 1'b0;
    chk("drain_empty_n", rd_empty_n, 0);
    chk("drain_count", fifo_count, 0);
    chk("drain_full", wr_full, 0);
    chk("drain_afull", wr_afull, 0);
    chk("drain_dout_zero", rd_dout, 0);

    // Steady state at count=5 across pointer wrap.
    wr_write = 1'b1;
    for (int i = 101; i <= 105; i++) begin
      wr_din = word_f(i);
      tick();
    end
    chk("ss_count0", fifo_count, 5);
    rd_read = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_din = word_f(106 + k);
      chk($sformatf("ss_dout_%0d", k), rd_dout, word_f(101 + k));
      tick();
      chk($sformatf("ss_count_%0d", k), fifo_count, 5);
    end
    wr_write = 1'b0;
    for (int i = 141; i <= 145; i++) begin
      chk($sformatf("ss_tail_%0d", i), rd_dout, word_f(i));
      tick();
    end
    rd_read = 1'b0;
    chk("ss_empty_n", rd_empty_n, 0);

    // Empty + write + read: read ignored, word stored.
    wr_write = 1'b1;
    rd_read  = 1'b1;
    wr_din   = word_f(200);
    tick();
    rd_read = 1'b0;
    wr_write = 1'b0;
    chk("ew_count", fifo_count, 1);
    chk("ew_empty_n", rd_empty_n, 1);
    chk("ew_dout", rd_dout, word_f(200));
    tick();
    chk("ew_dout_hold", rd_dout, word_f(200));

    // Full + write + read: pop happens, write lost.
    wr_write = 1'b1;
    for (int i = 201; i <= 215; i++) begin
      wr_din = word_f(i);
      tick();
    end
    chk("fr_full_pre", wr_full, 1);
    rd_read = 1'b1;
    wr_din  = 128'hBEEF;
    tick();
    wr_write = 1'b0;
    chk("fr_count", fifo_count, 15);
    chk("fr_full", wr_full, 0);
    for (int i = 201; i <= 215; i++) begin
      chk($sformatf("fr_dout_%0d", i), rd_dout, word_f(i));
      tick();
    end
    rd_read = 1'b0;
    chk("fr_empty_n", rd_empty_n, 0);

    // Asynchronous reset mid-cycle with 9 words held.
    wr_write = 1'b1;
    for (int i = 50; i <= 58; i++) begin
      wr_din = word_f(i);
      tick();
    end
    wr_write = 1'b0;
    chk("ar_count_pre", fifo_count, 9);
    chk("ar_afull_pre", wr_afull, 0);
    #2;
    ip_rst_n = 1'b0;
    #1;
    chk("ar_count", fifo_count, 0);
    chk("ar_empty_n", rd_empty_n, 0);
    chk("ar_full", wr_full, 0);
    chk("ar_dout", rd_dout, 0);
`ifdef HCODE_FIFO_ERR_EN
    chk("ar_err_ovf", err_ovf, 0);
    chk("ar_err_udf", err_udf, 0);
`endif
    tick();
    ip_rst_n = 1'b1;
    tick();
    wr_write = 1'b1;
    wr_din   = word_f(77);
    tick();
    wr_write = 1'b0;
    chk("post_count", fifo_count, 1);
    chk("post_dout", rd_dout, word_f(77));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
